vector_data_memory: RTL

//  Parametrised vector data memory for the PE array: DEPTH rows of DATA_W bits.
//  One lane-masked write port, one registered read port with a valid flag, and
//  N_TAPS registered row taps (rows 0..N_TAPS-1) feeding the PEs in parallel.

---
 rtl/vector_data_memory.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vector_data_memory.sv
// Vector data memory for the PE array: lane-masked write port, registered read port,
// parallel registered row taps and a sequenced bulk-clear engine.
module vector_data_memory #(
  parameter  int DATA_W = 512,
  parameter  int DEPTH  = 32,
  parameter  int LANE_W = 32,
  parameter  int N_TAPS = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NLANE  = DATA_W / LANE_W
) (
  input  logic                     CLK,
  input  logic                     MEMRST,
  input  logic                     CS,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [NLANE-1:0]         WrLaneEn,
  output logic                     WrReady,
  input  logic                     RdReq,
  input  logic [ADDR_W-1:0]        RdAddr,
  output logic [DATA_W-1:0]        RdData,
  output logic                     RdValid,
  input  logic                     TapEn,
  output logic [N_TAPS*DATA_W-1:0] Taps,
  input  logic                     ClrReq,
  output logic                     Busy
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

  logic [DATA_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [DATA_W-1:0] taps_reg [N_TAPS];
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              rd_valid_reg;

  logic wr_fire, rd_fire, rd_in_range, clr_start, clr_active;

  assign clr_active  = (state_reg == CLEAR);
  assign WrReady     = ~clr_active;
  assign Busy        = clr_active;
  assign wr_fire     = CS & WE & ~clr_active & ({1'b0, WrAddr} < DEPTH_X);
  assign rd_fire     = CS & RdReq;
  assign rd_in_range = ({1'b0, RdAddr} < DEPTH_X);
  assign clr_start   = CS & ClrReq & ~clr_active;

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        if (clr_ptr_reg == LAST_ROW) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Post-edge row image: lane-merged write, then clear wins. Reads and taps use it
  // so same-edge writes and clears are visible (write-first / clear-first).
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_next[r] = mem_reg[r];
      if (wr_fire && (WrAddr == ADDR_W'(r))) begin
        for (int k = 0; k < NLANE; k++) begin
          if (WrLaneEn[k]) begin
            mem_next[r][k*LANE_W +: LANE_W] = WrData[k*LANE_W +: LANE_W];
          end
        end
      end
      if (clr_active && (clr_ptr_reg == ADDR_W'(r))) begin
        mem_next[r] = '0;
      end
    end
  end

  always_comb begin
    rd_data_next = rd_data_reg;
    if (rd_fire) begin
      rd_data_next = rd_in_range ? mem_next[RdAddr] : '0;
    end
  end

  always_ff @(posedge CLK or posedge MEMRST) begin
    if (MEMRST) begin
      state_reg    <= IDLE;
      clr_ptr_reg  <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      for (int r = 0; r < DEPTH; r++) mem_reg[r] <= '0;
      for (int t = 0; t < N_TAPS; t++) taps_reg[t] <= '0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_fire;
      for (int r = 0; r < DEPTH; r++) mem_reg[r] <= mem_next[r];
      if (TapEn) begin
        for (int t = 0; t < N_TAPS; t++) taps_reg[t] <= mem_next[t];
      end
    end
  end

  assign RdData  = rd_data_reg;
  assign RdValid = rd_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
      assign Taps[gi*DATA_W +: DATA_W] = taps_reg[gi];
    end
  endgenerate

endmodule
